// File: rtl/kb_game_keymap.sv
// kb_game_keymap: PS/2 scancode stream to per-slot game key levels/pulses.
// Define KB_AUTOREPEAT_EN to build the per-slot auto-repeat pulse counters.
module kb_game_keymap #(
  parameter int NUM_KEYS = 8,
  parameter logic [NUM_KEYS*9-1:0] DEFAULT_MAP = {
    9'h174, 9'h172, 9'h16B, 9'h175,
    9'h023, 9'h01B, 9'h01C, 9'h01D
  },
  parameter int REPEAT_DELAY  = 16250000,
  parameter int REPEAT_PERIOD = 2166666
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_valid,
  input  logic [7:0]          rx_byte,
  input  logic                cfg_we,
  input  logic [4:0]          cfg_idx,
  input  logic [8:0]          cfg_code,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press_pulse,
  output logic [NUM_KEYS-1:0] key_release_pulse,
  output logic [NUM_KEYS-1:0] key_repeat_pulse
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  state_t state_q, state_d;
  logic   term, is_ext, is_brk;

  logic [8:0]          map_q [NUM_KEYS];
  logic [NUM_KEYS-1:0] hit, cfg_clr, held_d;

  always_comb begin
    state_d = state_q;
    term    = 1'b0;
    is_ext  = (state_q == S_EXT) || (state_q == S_EXT_BRK);
    is_brk  = (state_q == S_BRK) || (state_q == S_EXT_BRK);
    if (rx_valid) begin
      unique case (1'b1)
        (rx_byte == 8'hE0): begin
          if (state_q == S_IDLE) state_d = S_EXT;
          else if (state_q == S_BRK) state_d = S_EXT_BRK;
        end
        (rx_byte == 8'hF0): begin
          if (state_q == S_IDLE) state_d = S_BRK;
          else if (state_q == S_EXT) state_d = S_EXT_BRK;
        end
        default: begin
          state_d = S_IDLE;
          // pause/BAT/ack/resend/echo never map to a key
          term = !(rx_byte inside
            {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE});
        end
      endcase
    end
  end

  always_comb begin
    hit     = '0;
    cfg_clr = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      hit[i] = term && (map_q[i] == {is_ext, rx_byte});
      cfg_clr[i] = cfg_we && (cfg_idx == i[4:0]);
    end
    held_d = is_brk ? (key_held & ~hit) : (key_held | hit);
    held_d = held_d & ~cfg_clr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= S_IDLE;
      key_held          <= '0;
      key_press_pulse   <= '0;
      key_release_pulse <= '0;
      for (int i = 0; i < NUM_KEYS; i++)
        map_q[i] <= DEFAULT_MAP[9*i +: 9];
    end else begin
      state_q           <= state_d;
      key_held          <= held_d;
      key_press_pulse   <= held_d & ~key_held;
      key_release_pulse <= key_held & ~held_d & ~cfg_clr;
      for (int i = 0; i < NUM_KEYS; i++)
        if (cfg_clr[i]) map_q[i] <= cfg_code;
    end
  end

`ifdef KB_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW = $clog2(RMAX + 1);
  localparam logic [CW-1:0] DLY = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PER = CW'(REPEAT_PERIOD);

  logic [CW-1:0]       cnt_q [NUM_KEYS];
  logic [NUM_KEYS-1:0] phase_q;

  // phase_q: 0 waits for the first delay, 1 runs the period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_repeat_pulse <= '0;
      phase_q          <= '0;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        key_repeat_pulse[i] <= 1'b0;
        if (key_held[i] && held_d[i]) begin
          if (cnt_q[i] + CW'(1) == (phase_q[i] ? PER : DLY)) begin
            key_repeat_pulse[i] <= 1'b1;
            cnt_q[i]            <= '0;
            phase_q[i]          <= 1'b1;
          end else begin
            cnt_q[i] <= cnt_q[i] + CW'(1);
          end
        end else begin
          cnt_q[i]   <= '0;
          phase_q[i] <= 1'b0;
        end
      end
    end
  end
`else
  logic unused_rpt;
  assign unused_rpt       = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign key_repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_kb_game_keymap.sv
// tb_kb_game_keymap: directed + random scancode stimulus against a
// behavioural key-table model; repeat timing derived from press age.
module tb_kb_game_keymap;

`ifdef KB_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  localparam int DLY = 10;
  localparam int PER = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       cfg_we = 1'b0;
  logic [4:0] cfg_idx = 5'd0;
  logic [8:0] cfg_code = 9'h000;
  logic [7:0] key_held, key_press_pulse;
  logic [7:0] key_release_pulse, key_repeat_pulse;

  kb_game_keymap #(
    .NUM_KEYS(8),
    .REPEAT_DELAY(DLY),
    .REPEAT_PERIOD(PER)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .cfg_we(cfg_we),
    .cfg_idx(cfg_idx),
    .cfg_code(cfg_code),
    .key_held(key_held),
    .key_press_pulse(key_press_pulse),
    .key_release_pulse(key_release_pulse),
    .key_repeat_pulse(key_repeat_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int step = 0;

  bit [8:0] def_map [8] = '{9'h01D, 9'h01C, 9'h01B, 9'h023,
                           9'h175, 9'h16B, 9'h172, 9'h174};
  bit [7:0] codes [9] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75,
                         8'h6B, 8'h72, 8'h74, 8'h29};
  bit [7:0] specials [5] = '{8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE};

  bit [8:0] m_map [8];
  bit [7:0] m_held;
  bit       m_ext, m_brk;
  int       age [8];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s step=%0d got=%0h exp=%0h", tag, step, got, exp);
    end
  endtask

  task automatic model_reset();
    m_map  = def_map;
    m_held = '0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    for (int i = 0; i < 8; i++) age[i] = 0;
  endtask

  task automatic cycle(input bit rx, input bit [7:0] b,
                       input bit we, input bit [4:0] idx,
                       input bit [8:0] code);
    bit [7:0] prev, nh, ep, er, erep;
    step++;
    rx_valid = rx;
    rx_byte  = b;
    cfg_we   = we;
    cfg_idx  = idx;
    cfg_code = code;
    @(negedge clk);
    rx_valid = 1'b0;
    cfg_we   = 1'b0;
    prev = m_held;
    nh   = m_held;
    if (rx) begin
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        if (!(b inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE}))
          for (int i = 0; i < 8; i++)
            if (m_map[i] == {m_ext, b}) nh[i] = !m_brk;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
    ep = nh & ~prev;
    er = prev & ~nh;
    if (we && idx < 8) begin
      m_map[idx] = code;
      nh[idx] = 1'b0;
      ep[idx] = 1'b0;
      er[idx] = 1'b0;
    end
    erep = '0;
    for (int i = 0; i < 8; i++) begin
      if (prev[i] && nh[i]) begin
        age[i]++;
        if (AR && age[i] >= DLY && (age[i] - DLY) % PER == 0)
          erep[i] = 1'b1;
      end else begin
        age[i] = 0;
      end
    end
    m_held = nh;
    chk("held", key_held, m_held);
    chk("press", key_press_pulse, ep);
    chk("release", key_release_pulse, er);
    chk("repeat", key_repeat_pulse, erep);
  endtask

  task automatic rx(input bit [7:0] b);
    cycle(1'b1, b, 1'b0, 5'd0, 9'h000);
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 5'd0, 9'h000);
  endtask

  task automatic cfg(input bit [4:0] idx, input bit [8:0] code);
    cycle(1'b0, 8'h00, 1'b1, idx, code);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_held", key_held, 8'h00);
    chk("rst_press", key_press_pulse, 8'h00);
    chk("rst_release", key_release_pulse, 8'h00);
    chk("rst_repeat", key_repeat_pulse, 8'h00);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int np, nr, r;
    bit [7:0] b;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1) W make then break
    rx(8'h1D);
    chk("t1_held", key_held, 8'h01);
    chk("t1_press", key_press_pulse, 8'h01);
    idle();
    chk("t1_press_1cyc", key_press_pulse, 8'h00);
    rx(8'hF0);
    rx(8'h1D);
    chk("t1_held_off", key_held, 8'h00);
    chk("t1_release", key_release_pulse, 8'h01);

    // 2) extended up-arrow, non-ext 75 unmapped
    rx(8'hE0);
    rx(8'h75);
    chk("t2_up", key_held, 8'h10);
    rx(8'h75);
    chk("t2_plain75", key_held, 8'h10);
    rx(8'hE0);
    rx(8'hF0);
    rx(8'h75);
    chk("t2_up_off", key_held, 8'h00);

    // 3) typematic repeats give one press pulse
    np = 0;
    for (int k = 0; k < 5; k++) begin
      rx(8'h1D);
      np += int'(key_press_pulse[0]);
    end
    chk("t3_one_press", np, 1);
    chk("t3_held", key_held, 8'h01);

    // 4) reprogram held slot: silent clear
    cfg(5'd0, 9'h029);
    chk("t4_clr", key_held, 8'h00);
    chk("t4_no_rel", key_release_pulse, 8'h00);
    rx(8'h29);
    chk("t4_space", key_held, 8'h01);
    rx(8'hF0);
    rx(8'h29);

    // cfg write beats concurrent make; out-of-range write ignored
    cycle(1'b1, 8'h1C, 1'b1, 5'd1, 9'h01C);
    chk("cfg_vs_make", key_held, 8'h00);
    cfg(5'd9, 9'h01D);
    rx(8'h1C);
    chk("cfg_oor", key_held, 8'h02);

    // 5) reset after E0 F0 drops the prefix
    rx(8'hE0);
    rx(8'hF0);
    do_reset();
    rx(8'h1C);
    chk("t5_a", key_held, 8'h02);
    rx(8'hFA);
    rx(8'hE1);
    chk("t5_special", key_held, 8'h02);

    // 6) auto-repeat timing on slot 0
    rx(8'h1D);
    chk("t6_press", key_press_pulse, 8'h01);
    nr = 0;
    for (int k = 1; k <= 20; k++) begin
      idle();
      nr += int'(key_repeat_pulse[0]);
    end
    chk("t6_rep_count", nr, AR ? 3 : 0);
    rx(8'hF0);
    rx(8'h1D);
    for (int k = 0; k < 6; k++) idle();

    // random stream against the model
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 19);
      if (r < 3) b = 8'hE0;
      else if (r < 5) b = 8'hF0;
      else if (r < 6) b = specials[$urandom_range(0, 4)];
      else if (r < 14) b = codes[$urandom_range(0, 8)];
      else b = 8'($urandom);
      if ($urandom_range(0, 15) == 0)
        cycle(r < 17, b, 1'b1, 5'($urandom_range(0, 9)),
              {1'($urandom), codes[$urandom_range(0, 8)]});
      else if (r >= 17)
        idle();
      else
        rx(b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
